// File: rtl/fifo_rd_stream_adapter.sv
// Drains a FIFO read port into a valid/ready stream through a small skid buffer.
// Optional o_Last packet marker: define FIFO_RD_STREAM_LAST_EN.
module fifo_rd_stream_adapter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BUF_DEPTH  = RD_LATENCY + 1,
  parameter int unsigned PKT_LEN    = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Enable,
  output logic             o_Fifo_Rd_En,
  input  logic [WIDTH-1:0] i_Fifo_Rd_Data,
  input  logic             i_Fifo_Empty,
  output logic             o_DV,
  output logic [WIDTH-1:0] o_Data,
  input  logic             i_Ready,
`ifdef FIFO_RD_STREAM_LAST_EN
  output logic             o_Last,
`endif
  output logic             o_Busy
);

  localparam int unsigned OccW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned SumW = OccW + 1;

  if (RD_LATENCY == 0 || RD_LATENCY > 3 || BUF_DEPTH < RD_LATENCY + 1 || PKT_LEN == 0)
  begin : g_param_chk
    $error("fifo_rd_stream_adapter: illegal parameter combination");
  end

  logic [OccW-1:0]       r_Occ;
  logic [PtrW-1:0]       r_Wr_Ptr;
  logic [PtrW-1:0]       r_Rd_Ptr;
  logic [RD_LATENCY-1:0] r_Pipe;
  logic [WIDTH-1:0]      r_Buf [BUF_DEPTH];

  logic            w_Pop;
  logic            w_Capture;
  logic [SumW-1:0] w_Inflight;
  logic            w_Room;

  function automatic logic [PtrW-1:0] f_next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_Pop     = o_DV & i_Ready;
  assign w_Capture = r_Pipe[RD_LATENCY-1];

  // Every pipe bit (including the one landing now) is a word that still needs a slot.
  always_comb begin
    w_Inflight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      w_Inflight = w_Inflight + SumW'(r_Pipe[i]);
    end
  end

  assign w_Room = (SumW'(r_Occ) + w_Inflight - SumW'(w_Pop)) < SumW'(BUF_DEPTH);

  // Issue is decided and driven in the same clock: the empty flag is then exact, and a
  // BUF_DEPTH of RD_LATENCY+1 still sustains one word per clock.
  assign o_Fifo_Rd_En = i_Rst_L & i_Enable & ~i_Fifo_Empty & w_Room;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Occ    <= '0;
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Pipe   <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        r_Buf[i] <= '0;
      end
    end else begin
      r_Pipe <= (r_Pipe << 1) | RD_LATENCY'(o_Fifo_Rd_En);
      if (w_Capture) begin
        r_Buf[r_Wr_Ptr] <= i_Fifo_Rd_Data;
        r_Wr_Ptr        <= f_next_ptr(r_Wr_Ptr);
      end
      if (w_Pop) begin
        r_Rd_Ptr <= f_next_ptr(r_Rd_Ptr);
      end
      case ({w_Capture, w_Pop})
        2'b10:   r_Occ <= r_Occ + 1'b1;
        2'b01:   r_Occ <= r_Occ - 1'b1;
        default: r_Occ <= r_Occ;
      endcase
    end
  end

  assign o_DV   = (r_Occ != '0);
  assign o_Data = r_Buf[r_Rd_Ptr];
  assign o_Busy = (r_Occ != '0) | (r_Pipe != '0) | o_Fifo_Rd_En;

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int unsigned CntW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [CntW-1:0] r_Beat;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Beat <= '0;
    end else if (w_Pop) begin
      r_Beat <= (r_Beat == CntW'(PKT_LEN - 1)) ? '0 : r_Beat + 1'b1;
    end
  end

  assign o_Last = o_DV & (r_Beat == CntW'(PKT_LEN - 1));
`else
`endif

`ifndef SYNTHESIS
  always @(posedge i_Clk) begin
    if (i_Rst_L && w_Capture && !w_Pop && (r_Occ == OccW'(BUF_DEPTH))) begin
      $error("fifo_rd_stream_adapter: skid buffer overflow");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: u_a (RD_LATENCY=1, BUF_DEPTH=2) and u_b (RD_LATENCY=3, BUF_DEPTH=4),
// each fed by a small behavioural FIFO with matching read latency.
module tb_fifo_rd_stream_adapter;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic ready_a, ready_b;
  logic rd_en_a, empty_a, dv_a, busy_a;
  logic rd_en_b, empty_b, dv_b, busy_b;
  logic [7:0] rd_a, data_a, rd_b, data_b;
`ifdef FIFO_RD_STREAM_LAST_EN
  logic last_a;
`endif

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] dp_b [3];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  int viol_a = 0, viol_b = 0;
  logic flush_a = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(2), .PKT_LEN(4)) u_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(enable), .o_Fifo_Rd_En(rd_en_a),
    .i_Fifo_Rd_Data(rd_a), .i_Fifo_Empty(empty_a), .o_DV(dv_a), .o_Data(data_a),
    .i_Ready(ready_a),
`ifdef FIFO_RD_STREAM_LAST_EN
    .o_Last(last_a),
`endif
    .o_Busy(busy_a)
  );

  fifo_rd_stream_adapter #(.WIDTH(8), .RD_LATENCY(3), .BUF_DEPTH(4), .PKT_LEN(16)) u_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(enable), .o_Fifo_Rd_En(rd_en_b),
    .i_Fifo_Rd_Data(rd_b), .i_Fifo_Empty(empty_b), .o_DV(dv_b), .o_Data(data_b),
    .i_Ready(ready_b),
`ifdef FIFO_RD_STREAM_LAST_EN
    .o_Last(),
`endif
    .o_Busy(busy_b)
  );

  assign empty_a = (rp_a == wp_a);
  assign empty_b = (rp_b == wp_b);
  assign rd_b    = dp_b[2];

  always @(posedge clk) begin
    if (flush_a) begin
      rp_a <= wp_a;
    end else if (rd_en_a) begin
      if (rp_a == wp_a) viol_a <= viol_a + 1;
      rd_a <= mem_a[rp_a[7:0]];
      rp_a <= rp_a + 1;
    end
  end

  always @(posedge clk) begin
    dp_b[1] <= dp_b[0];
    dp_b[2] <= dp_b[1];
    if (rd_en_b) begin
      if (rp_b == wp_b) viol_b <= viol_b + 1;
      dp_b[0] <= mem_b[rp_b[7:0]];
      rp_b    <= rp_b + 1;
    end
  end

  task automatic push_a(input logic [7:0] d);
    mem_a[wp_a[7:0]] = d;
    wp_a = wp_a + 1;
  endtask

  task automatic push_b(input logic [7:0] d);
    mem_b[wp_b[7:0]] = d;
    wp_b = wp_b + 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (rd_en_a !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", rd_en_a);
    else n_pass++;
    n_checks++; if (dv_a !== 1'b0) $display("FAIL rst_dv: got %b want 0", dv_a); else n_pass++;
    n_checks++; if (data_a !== 8'h00) $display("FAIL rst_data: got %h want 00", data_a);
    else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_a);
    else n_pass++;
    n_checks++; if (dv_b !== 1'b0 || busy_b !== 1'b0)
      $display("FAIL rst_b: got dv=%b busy=%b want 0 0", dv_b, busy_b);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_rate();
    int lat;
    ready_a = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) push_a(8'(i));
    lat = 0;
    while (dv_a !== 1'b1 && lat < 6) begin
      @(negedge clk); #1; lat++;
    end
    n_checks++; if (lat != 2) $display("FAIL fr_latency: got %0d want 2", lat); else n_pass++;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      n_checks++;
      if (dv_a !== 1'b1 || data_a !== 8'(k))
        $display("FAIL fr_beat%0d: got dv=%b data=%h want dv=1 data=%h", k, dv_a, data_a, 8'(k));
      else n_pass++;
    end
    @(negedge clk); #1;
    n_checks++; if (dv_a !== 1'b0) $display("FAIL fr_drained: got dv=%b want 0", dv_a);
    else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL fr_busy: got %b want 0", busy_a);
    else n_pass++;
    n_checks++; if (viol_a != 0) $display("FAIL fr_rd_empty: got %0d want 0", viol_a);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    logic [7:0] pdata;
    int got, c, max_occ;
    logic pdv, prdy;
    pat = 4'b1001;
    got = 0; c = 0; max_occ = 0; pdv = 1'b0; prdy = 1'b0; pdata = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 20; i++) push_a(8'(8'h40 + i));
    while (got < 20 && c < 200) begin
      ready_a = pat[c % 4];
      #1;
      if (int'(u_a.r_Occ) > max_occ) max_occ = int'(u_a.r_Occ);
      if (pdv && !prdy) begin
        n_checks++;
        if (dv_a !== 1'b1 || data_a !== pdata)
          $display("FAIL bp_hold: got dv=%b data=%h want dv=1 data=%h", dv_a, data_a, pdata);
        else n_pass++;
      end
      if (dv_a && ready_a) begin
        n_checks++;
        if (data_a !== 8'(8'h40 + got))
          $display("FAIL bp_word%0d: got %h want %h", got, data_a, 8'(8'h40 + got));
        else n_pass++;
        got++;
      end
      pdv = dv_a; prdy = ready_a; pdata = data_a;
      c++;
      @(negedge clk);
    end
    ready_a = 1'b1;
    n_checks++; if (got != 20) $display("FAIL bp_count: got %0d want 20", got); else n_pass++;
    n_checks++; if (max_occ > 2) $display("FAIL bp_occ: got %0d want <=2", max_occ);
    else n_pass++;
  endtask

  task automatic test_single();
    int pulses, beats;
    logic [7:0] bdata;
    pulses = 0; beats = 0; bdata = 8'h00;
    ready_a = 1'b1;
    @(negedge clk);
    push_a(8'hA5);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rd_en_a) pulses++;
      if (dv_a && ready_a) begin beats++; bdata = data_a; end
      @(negedge clk);
    end
    #1;
    n_checks++; if (pulses != 1) $display("FAIL sw_pulses: got %0d want 1", pulses);
    else n_pass++;
    n_checks++; if (beats != 1 || bdata !== 8'hA5)
      $display("FAIL sw_beat: got %0d beats data=%h want 1 beat data=a5", beats, bdata);
    else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL sw_busy: got %b want 0", busy_a);
    else n_pass++;
  endtask

  task automatic test_enable();
    int bad, got, c;
    bad = 0; got = 0; c = 0;
    enable = 1'b0;
    ready_a = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_a(8'(8'h20 + i));
    for (int i = 0; i < 6; i++) begin
      #1;
      if (rd_en_a || dv_a || busy_a) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) $display("FAIL en_idle: got %0d active cycles want 0", bad);
    else n_pass++;
    enable = 1'b1;
    while (got < 4 && c < 20) begin
      #1;
      if (dv_a && ready_a) begin
        n_checks++;
        if (data_a !== 8'(8'h20 + got))
          $display("FAIL en_word%0d: got %h want %h", got, data_a, 8'(8'h20 + got));
        else n_pass++;
        got++;
      end
      c++;
      @(negedge clk);
    end
    n_checks++; if (got != 4) $display("FAIL en_count: got %0d want 4", got); else n_pass++;
  endtask

  task automatic test_latency_sweep();
    int lat;
    ready_b = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) push_b(8'(8'h80 + i));
    lat = 0;
    while (dv_b !== 1'b1 && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    n_checks++; if (lat != 4) $display("FAIL ls_latency: got %0d want 4", lat); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      n_checks++;
      if (dv_b !== 1'b1 || data_b !== 8'(8'h80 + k))
        $display("FAIL ls_beat%0d: got dv=%b data=%h want dv=1 data=%h",
                 k, dv_b, data_b, 8'(8'h80 + k));
      else n_pass++;
    end
    @(negedge clk); #1;
    n_checks++; if (busy_b !== 1'b0) $display("FAIL ls_busy: got %b want 0", busy_b);
    else n_pass++;
    n_checks++; if (viol_b != 0) $display("FAIL ls_rd_empty: got %0d want 0", viol_b);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pops, c, lat;
    pops = 0; c = 0;
    ready_a = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) push_a(8'(8'h60 + i));
    while (pops < 3 && c < 20) begin
      #1;
      if (dv_a && ready_a) pops++;
      c++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_en_a !== 1'b0 || dv_a !== 1'b0 || data_a !== 8'h00 || busy_a !== 1'b0)
      $display("FAIL rm_in_reset: got rd_en=%b dv=%b data=%h busy=%b want 0 0 00 0",
               rd_en_a, dv_a, data_a, busy_a);
    else n_pass++;
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'(8'h10 + i));
    #1;
    n_checks++; if (rd_en_a !== 1'b0 || dv_a !== 1'b0)
      $display("FAIL rm_hold: got rd_en=%b dv=%b want 0 0", rd_en_a, dv_a);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    while (dv_a !== 1'b1 && lat < 6) begin
      @(negedge clk); #1; lat++;
    end
    n_checks++; if (lat > 2) $display("FAIL rm_latency: got %0d want <=2", lat); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      n_checks++;
      if (dv_a !== 1'b1 || data_a !== 8'(8'h10 + k))
        $display("FAIL rm_word%0d: got dv=%b data=%h want dv=1 data=%h",
                 k, dv_a, data_a, 8'(8'h10 + k));
      else n_pass++;
    end
    n_checks++; if (viol_a != 0) $display("FAIL rm_rd_empty: got %0d want 0", viol_a);
    else n_pass++;
  endtask

`ifdef FIFO_RD_STREAM_LAST_EN
  task automatic test_last();
    int beats, c;
    logic exp_last;
    beats = 0; c = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) push_a(8'(8'hC0 + i));
    while (beats < 12 && c < 300) begin
      ready_a = 1'($urandom_range(0, 1));
      #1;
      if (dv_a && ready_a) begin
        exp_last = ((beats + 1) % 4 == 0);
        n_checks++;
        if (last_a !== exp_last)
          $display("FAIL last_beat%0d: got %b want %b", beats + 1, last_a, exp_last);
        else n_pass++;
        beats++;
      end
      c++;
      @(negedge clk);
    end
    ready_a = 1'b1;
    n_checks++; if (beats != 12) $display("FAIL last_count: got %0d want 12", beats);
    else n_pass++;
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_single();
    test_enable();
    test_latency_sweep();
    test_reset_mid();
`ifdef FIFO_RD_STREAM_LAST_EN
    test_last();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
